axi_ar_beat_gen: RTL and testbench
==================================

Name: axi_ar_beat_gen

Overview:
- Sits directly downstream of the AR-channel buffer in the AXI-to-memory read path; consumes one buffered AR request at a time.
- Expands the request into one memory-side read request per beat, each with its own address, and marks the last beat.
- Supports FIXED, INCR and WRAP bursts.
- Back-to-back bursts run without bubbles.

Parameters:
- ID_WIDTH, 4, width of AXI ID
- ADDR_WIDTH, 32, width of address (>=12)
- USER_WIDTH, 1, width of AR user field
- DATA_WIDTH, 64, bus data width in bits; bus bytes NB = DATA_WIDTH/8, power of two, 8..1024

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- slave_valid_i  in  1  AR request valid (from AR buffer master side)
- slave_addr_i  in  ADDR_WIDTH  start address
- slave_len_i  in  8  beats-1
- slave_size_i  in  3  log2 bytes per beat
- slave_burst_i  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved
- slave_id_i  in  ID_WIDTH  transaction ID
- slave_user_i  in  USER_WIDTH  user field
- slave_ready_o  out  1  AR accepted when valid&ready
- beat_valid_o  out  1  beat request valid
- beat_addr_o  out  ADDR_WIDTH  beat address
- beat_size_o  out  3  beat size (copied)
- beat_id_o  out  ID_WIDTH  copied ID
- beat_user_o  out  USER_WIDTH  copied user
- beat_last_o  out  1  final beat of burst
- beat_ready_i  in  1  memory side accepts beat
- busy_o  out  1  burst in progress (= beat_valid_o)

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_i is synchronous and active-high.
- Reset:
  - All registered outputs go to 0; state goes to IDLE.
  - slave_ready_o is forced to 0 while rst_i=1.
  - Reset mid-burst drops the remaining beats silently; the beat counter is cleared.
- States:
  - IDLE: slave_ready_o=1, beat_valid_o=0.
  - BURST: beat_valid_o=1. slave_ready_o = beat_ready_i & beat_last_o, so the next AR overlaps the final beat handshake.
- Transitions:
  - IDLE->BURST on AR handshake.
  - BURST->IDLE on last-beat handshake with no new AR.
  - BURST->BURST on last-beat handshake with a new AR; the new burst's first beat is presented the next cycle, with zero bubble.
- Latency: first beat appears 1 cycle after the AR handshake. One beat per cycle while beat_ready_i=1.
- beat_valid_o and all beat_* fields hold stable while beat_valid_o & !beat_ready_i.
- Counter: 8-bit remaining-beats count, loaded with len. beat_last_o = (count==0). It decrements on each beat handshake.
- Address generation, applied per beat handshake:
  - FIXED: address unchanged for every beat.
  - INCR: first beat uses the unaligned start address. Next address = (addr aligned down to 2^size) + 2^size. Only bits [11:0] increment; bits above 11 are held, so a 4KB crossing wraps inside the page and never carries.
  - WRAP: span = (len+1)<<size, lower = addr & ~(span-1). Next = addr+2^size; if next == lower+span, next = lower. The start address is used unaligned only as given; the spec requires aligned starts.
  - WRAP with len not in {1,3,7,15} is treated as INCR.
  - Reserved burst 11 is treated as INCR.
  - size > log2(NB) is clamped to log2(NB) for address stepping only; beat_size_o still carries the raw value.
- Arithmetic: shifts computed at 12-bit width; no overflow beyond bit 11.
- Simultaneous events: a new AR is accepted only in IDLE or on the last-beat handshake. slave_valid_i without slave_ready_o is ignored, and its fields are not sampled.

Decomposition:
- Package axi_beat_pkg holds:
  - Burst encodings BURST_FIXED/INCR/WRAP.
  - State enum {IDLE, BURST}.
  - Constant PAGE_BITS=12.
  - Function legal_wrap_len(len).
- One sub-module, axi_beat_addr_next: purely combinational next-address computation. Inputs addr, len, size, burst; output next addr. It is unit-testable separately.

Test Plan:
- INCR, addr 0x1004, size 2, len 3, beat_ready_i=1 -> beats 0x1004, 0x1008, 0x100C, 0x1010 on 4 consecutive cycles starting 1 cycle after AR; last only on 0x1010.
- WRAP, addr 0x0038, size 3, len 3 -> 0x38, 0x20, 0x28, 0x30; last on 0x30.
- FIXED, addr 0x200, len 2, beat_ready_i toggling 1,0,1,0,1 -> 3 beats all 0x200. Fields stable during stalls; last on 3rd handshake.
- INCR, addr 0x1FF8, size 3, len 1 -> 0x1FF8, 0x1000 (page wrap, no carry into bit 12).
- Back-to-back: AR#1 (len 0, id 1) then AR#2 (id 2) held valid -> AR#2 accepted on the cycle of the AR#1 beat handshake. Beats for id 1 and id 2 appear on consecutive cycles; busy_o never drops.
- rst_i pulsed during beat 2 of a len-7 INCR -> next cycle beat_valid_o=0, slave_ready_o=1. A following AR with len 0 yields exactly one beat with last=1.

Source files
------------

// File: rtl/axi_beat_pkg.sv
// Shared definitions for the AR-to-beat expansion path.
//   burst_t        : AXI burst encodings (FIXED/INCR/WRAP, 11 reserved)
//   state_t        : beat generator FSM states
//   PAGE_BITS      : address bits that may change while stepping (4KB page)
//   legal_wrap_len : true when len is a legal WRAP length (2/4/8/16 beats)
package axi_beat_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10,
    BURST_RSVD  = 2'b11
  } burst_t;

  typedef enum logic {
    IDLE,
    BURST
  } state_t;

  localparam int unsigned PAGE_BITS = 12;

  function automatic logic legal_wrap_len(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

endpackage

// File: rtl/axi_beat_addr_next.sv
// Combinational next-beat address for one AXI burst step.
//   addr      : current beat address
//   len       : burst length (beats-1), selects the WRAP span
//   size      : log2 bytes per beat (clamped to the bus width for stepping)
//   burst     : burst type; illegal WRAP lengths and reserved type step as INCR
//   next_addr : address of the following beat; bits above the page never change
module axi_beat_addr_next
  import axi_beat_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 64
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [7:0]            len,
  input  logic [2:0]            size,
  input  logic [1:0]            burst,
  output logic [ADDR_WIDTH-1:0] next_addr
);

  localparam int unsigned NB       = DATA_WIDTH / 8;
  localparam logic [2:0]  MAX_SIZE = 3'($clog2(NB));

  logic [2:0]           eff_size;
  logic [PAGE_BITS-1:0] step;
  logic [PAGE_BITS-1:0] page_off;
  logic [PAGE_BITS-1:0] incr_off;
  logic [PAGE_BITS-1:0] wrap_span;
  logic [PAGE_BITS-1:0] wrap_lower;
  logic [PAGE_BITS-1:0] wrap_sum;
  logic [PAGE_BITS-1:0] wrap_off;

  always_comb begin
    eff_size   = (size > MAX_SIZE) ? MAX_SIZE : size;
    step       = PAGE_BITS'(1) << eff_size;
    page_off   = addr[PAGE_BITS-1:0];
    // INCR aligns down first so an unaligned start lands on the next boundary
    incr_off   = (page_off & ~(step - PAGE_BITS'(1))) + step;
    wrap_span  = (PAGE_BITS'(len) + PAGE_BITS'(1)) << eff_size;
    wrap_lower = page_off & ~(wrap_span - PAGE_BITS'(1));
    wrap_sum   = page_off + step;
    wrap_off   = (wrap_sum == wrap_lower + wrap_span) ? wrap_lower : wrap_sum;

    next_addr = addr;
    case (burst)
      BURST_FIXED: next_addr = addr;
      BURST_WRAP: begin
        if (legal_wrap_len(len)) next_addr[PAGE_BITS-1:0] = wrap_off;
        else                     next_addr[PAGE_BITS-1:0] = incr_off;
      end
      default:     next_addr[PAGE_BITS-1:0] = incr_off;
    endcase
  end

endmodule

// File: rtl/axi_ar_beat_gen.sv
// Expands one buffered AXI AR request into per-beat memory read requests.
//   clk_i, rst_i     : clock, synchronous active-high reset
//   slave_*          : AR request in (valid/ready handshake)
//   beat_*           : per-beat request out (valid/ready handshake), last flags final beat
//   busy_o           : burst in progress (mirrors beat_valid_o)
// A new AR is accepted in IDLE or alongside the final beat handshake, so
// consecutive bursts stream without an idle cycle.
module axi_ar_beat_gen
  import axi_beat_pkg::*;
#(
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned USER_WIDTH = 1,
  parameter int unsigned DATA_WIDTH = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  slave_valid_i,
  input  logic [ADDR_WIDTH-1:0] slave_addr_i,
  input  logic [7:0]            slave_len_i,
  input  logic [2:0]            slave_size_i,
  input  logic [1:0]            slave_burst_i,
  input  logic [ID_WIDTH-1:0]   slave_id_i,
  input  logic [USER_WIDTH-1:0] slave_user_i,
  output logic                  slave_ready_o,
  output logic                  beat_valid_o,
  output logic [ADDR_WIDTH-1:0] beat_addr_o,
  output logic [2:0]            beat_size_o,
  output logic [ID_WIDTH-1:0]   beat_id_o,
  output logic [USER_WIDTH-1:0] beat_user_o,
  output logic                  beat_last_o,
  input  logic                  beat_ready_i,
  output logic                  busy_o
);

  state_t                state;
  logic [7:0]            count;
  logic [7:0]            len_q;
  logic [1:0]            burst_q;
  logic [ADDR_WIDTH-1:0] next_addr;
  logic                  ar_hs;
  logic                  beat_hs;

  axi_beat_addr_next #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_addr_next (
    .addr      (beat_addr_o),
    .len       (len_q),
    .size      (beat_size_o),
    .burst     (burst_q),
    .next_addr (next_addr)
  );

  // beat_last_o is only ever set in BURST, so this reduces to the IDLE
  // acceptance plus overlap with the final beat handshake.
  assign slave_ready_o = !rst_i &&
                         ((state == IDLE) || (beat_valid_o && beat_ready_i && beat_last_o));
  assign ar_hs   = slave_valid_i && slave_ready_o;
  assign beat_hs = beat_valid_o && beat_ready_i;
  assign busy_o  = beat_valid_o;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= IDLE;
      beat_valid_o <= 1'b0;
      beat_addr_o  <= '0;
      beat_size_o  <= '0;
      beat_id_o    <= '0;
      beat_user_o  <= '0;
      beat_last_o  <= 1'b0;
      count        <= '0;
      len_q        <= '0;
      burst_q      <= '0;
    end else if (ar_hs) begin
      state        <= BURST;
      beat_valid_o <= 1'b1;
      beat_addr_o  <= slave_addr_i;
      beat_size_o  <= slave_size_i;
      beat_id_o    <= slave_id_i;
      beat_user_o  <= slave_user_i;
      beat_last_o  <= (slave_len_i == 8'd0);
      count        <= slave_len_i;
      len_q        <= slave_len_i;
      burst_q      <= slave_burst_i;
    end else if (beat_hs) begin
      if (beat_last_o) begin
        state        <= IDLE;
        beat_valid_o <= 1'b0;
        beat_last_o  <= 1'b0;
      end else begin
        beat_addr_o <= next_addr;
        count       <= count - 8'd1;
        beat_last_o <= (count == 8'd1);
      end
    end
  end

endmodule

// File: tb/tb_axi_ar_beat_gen.sv
module tb_axi_ar_beat_gen;

  typedef struct {
    logic [31:0] addr;
    logic [2:0]  size;
    logic [3:0]  id;
    logic [0:0]  user;
    logic        last;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        slave_valid_i = 1'b0;
  logic [31:0] slave_addr_i = '0;
  logic [7:0]  slave_len_i = '0;
  logic [2:0]  slave_size_i = '0;
  logic [1:0]  slave_burst_i = '0;
  logic [3:0]  slave_id_i = '0;
  logic [0:0]  slave_user_i = '0;
  logic        slave_ready_o;
  logic        beat_valid_o;
  logic [31:0] beat_addr_o;
  logic [2:0]  beat_size_o;
  logic [3:0]  beat_id_o;
  logic [0:0]  beat_user_o;
  logic        beat_last_o;
  logic        beat_ready_i = 1'b0;
  logic        busy_o;

  exp_t sb[$];
  exp_t e;
  int   total = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  axi_ar_beat_gen #(
    .ID_WIDTH   (4),
    .ADDR_WIDTH (32),
    .USER_WIDTH (1),
    .DATA_WIDTH (64)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .slave_valid_i (slave_valid_i),
    .slave_addr_i  (slave_addr_i),
    .slave_len_i   (slave_len_i),
    .slave_size_i  (slave_size_i),
    .slave_burst_i (slave_burst_i),
    .slave_id_i    (slave_id_i),
    .slave_user_i  (slave_user_i),
    .slave_ready_o (slave_ready_o),
    .beat_valid_o  (beat_valid_o),
    .beat_addr_o   (beat_addr_o),
    .beat_size_o   (beat_size_o),
    .beat_id_o     (beat_id_o),
    .beat_user_o   (beat_user_o),
    .beat_last_o   (beat_last_o),
    .beat_ready_i  (beat_ready_i),
    .busy_o        (busy_o)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
  endtask

  task automatic push_exp(input logic [31:0] a, input logic [2:0] s, input logic [3:0] id,
                          input logic u, input logic l);
    exp_t x;
    x.addr = a; x.size = s; x.id = id; x.user = u; x.last = l;
    sb.push_back(x);
  endtask

  // Called just after a posedge; returns just after the handshake posedge.
  task automatic send_ar(input logic [31:0] a, input logic [7:0] l, input logic [2:0] s,
                         input logic [1:0] b, input logic [3:0] id, input logic u);
    int unsigned n = 0;
    bit done = 1'b0;
    slave_addr_i = a; slave_len_i = l; slave_size_i = s;
    slave_burst_i = b; slave_id_i = id; slave_user_i = u;
    slave_valid_i = 1'b1;
    while (!done && n < 50) begin
      @(negedge clk);
      if (slave_ready_o) done = 1'b1;
      @(posedge clk);
      #1;
      n++;
    end
    slave_valid_i = 1'b0;
    if (!done) begin
      total++;
      $display("FAIL ar_timeout: got no AR handshake, required one within 50 cycles");
    end else begin
      check("first_beat_latency", 32'(beat_valid_o), 32'd1);
    end
  endtask

  task automatic wait_drain(input string name);
    int unsigned n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    check({name, "_drained"}, 32'(sb.size()), 32'd0);
    check({name, "_idle"}, 32'(beat_valid_o), 32'd0);
  endtask

  // Scoreboard monitor: every presented beat must match the queue head,
  // including while stalled; the head retires on handshake.
  always @(negedge clk) begin
    if (!rst_i && beat_valid_o) begin
      if (sb.size() == 0) begin
        total++;
        $display("FAIL unexpected_beat: got addr 0x%0h, required no beat", beat_addr_o);
      end else begin
        e = sb[0];
        check("beat_addr", beat_addr_o, e.addr);
        check("beat_size", 32'(beat_size_o), 32'(e.size));
        check("beat_id", 32'(beat_id_o), 32'(e.id));
        check("beat_user", 32'(beat_user_o), 32'(e.user));
        check("beat_last", 32'(beat_last_o), 32'(e.last));
        if (beat_ready_i) void'(sb.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, required finish within 200us");
    $fatal(1, "timeout");
  end

  initial begin
    logic tog [5];
    tog = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_slave_ready", 32'(slave_ready_o), 32'd0);
    check("rst_beat_valid", 32'(beat_valid_o), 32'd0);
    check("rst_beat_last", 32'(beat_last_o), 32'd0);
    check("rst_beat_addr", beat_addr_o, 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    @(posedge clk); #1;
    rst_i = 1'b0;
    @(negedge clk);
    check("idle_slave_ready", 32'(slave_ready_o), 32'd1);
    @(posedge clk); #1;

    // INCR unaligned start, four beats on consecutive cycles
    beat_ready_i = 1'b1;
    push_exp(32'h1004, 3'd2, 4'd3, 1'b1, 1'b0);
    push_exp(32'h1008, 3'd2, 4'd3, 1'b1, 1'b0);
    push_exp(32'h100C, 3'd2, 4'd3, 1'b1, 1'b0);
    push_exp(32'h1010, 3'd2, 4'd3, 1'b1, 1'b1);
    send_ar(32'h1004, 8'd3, 3'd2, 2'b01, 4'd3, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    check("incr_4cycles_empty", 32'(sb.size()), 32'd0);
    check("incr_4cycles_idle", 32'(beat_valid_o), 32'd0);

    // WRAP 4 x 8 bytes from 0x38
    push_exp(32'h38, 3'd3, 4'd4, 1'b0, 1'b0);
    push_exp(32'h20, 3'd3, 4'd4, 1'b0, 1'b0);
    push_exp(32'h28, 3'd3, 4'd4, 1'b0, 1'b0);
    push_exp(32'h30, 3'd3, 4'd4, 1'b0, 1'b1);
    send_ar(32'h38, 8'd3, 3'd3, 2'b10, 4'd4, 1'b0);
    wait_drain("wrap");

    // FIXED with stalling beat_ready_i
    push_exp(32'h200, 3'd2, 4'd5, 1'b1, 1'b0);
    push_exp(32'h200, 3'd2, 4'd5, 1'b1, 1'b0);
    push_exp(32'h200, 3'd2, 4'd5, 1'b1, 1'b1);
    send_ar(32'h200, 8'd2, 3'd2, 2'b00, 4'd5, 1'b1);
    for (int i = 0; i < 5; i++) begin
      beat_ready_i = tog[i];
      @(posedge clk);
      #1;
    end
    check("fixed_empty", 32'(sb.size()), 32'd0);
    check("fixed_idle", 32'(beat_valid_o), 32'd0);
    beat_ready_i = 1'b1;

    // INCR across 4KB boundary stays in page
    push_exp(32'h1FF8, 3'd3, 4'd6, 1'b0, 1'b0);
    push_exp(32'h1000, 3'd3, 4'd6, 1'b0, 1'b1);
    send_ar(32'h1FF8, 8'd1, 3'd3, 2'b01, 4'd6, 1'b0);
    wait_drain("page_wrap");

    // Oversized beat: steps by bus width, size passed through raw
    push_exp(32'h0, 3'd5, 4'd6, 1'b0, 1'b0);
    push_exp(32'h8, 3'd5, 4'd6, 1'b0, 1'b1);
    send_ar(32'h0, 8'd1, 3'd5, 2'b01, 4'd6, 1'b0);
    wait_drain("size_clamp");

    // WRAP with illegal length behaves as INCR
    push_exp(32'h38, 3'd3, 4'd7, 1'b0, 1'b0);
    push_exp(32'h40, 3'd3, 4'd7, 1'b0, 1'b0);
    push_exp(32'h48, 3'd3, 4'd7, 1'b0, 1'b1);
    send_ar(32'h38, 8'd2, 3'd3, 2'b10, 4'd7, 1'b0);
    wait_drain("wrap_illegal");

    // Reserved burst type behaves as INCR
    push_exp(32'h10, 3'd2, 4'd8, 1'b1, 1'b0);
    push_exp(32'h14, 3'd2, 4'd8, 1'b1, 1'b1);
    send_ar(32'h10, 8'd1, 3'd2, 2'b11, 4'd8, 1'b1);
    wait_drain("reserved");

    // WRAP of two beats
    push_exp(32'h4, 3'd2, 4'd9, 1'b0, 1'b0);
    push_exp(32'h0, 3'd2, 4'd9, 1'b0, 1'b1);
    send_ar(32'h4, 8'd1, 3'd2, 2'b10, 4'd9, 1'b0);
    wait_drain("wrap2");

    // Back-to-back bursts without a bubble
    push_exp(32'h3000, 3'd3, 4'd1, 1'b0, 1'b1);
    push_exp(32'h4000, 3'd3, 4'd2, 1'b1, 1'b0);
    push_exp(32'h4008, 3'd3, 4'd2, 1'b1, 1'b1);
    send_ar(32'h3000, 8'd0, 3'd3, 2'b01, 4'd1, 1'b0);
    send_ar(32'h4000, 8'd1, 3'd3, 2'b01, 4'd2, 1'b1);
    check("b2b_busy", 32'(busy_o), 32'd1);
    check("b2b_id2_first", 32'(beat_id_o), 32'd2);
    repeat (2) @(posedge clk);
    #1;
    check("b2b_consecutive_empty", 32'(sb.size()), 32'd0);
    check("b2b_idle", 32'(beat_valid_o), 32'd0);

    // Reset mid-burst drops remaining beats
    push_exp(32'h100, 3'd2, 4'd4, 1'b0, 1'b0);
    send_ar(32'h100, 8'd7, 3'd2, 2'b01, 4'd4, 1'b0);
    @(posedge clk);
    #1;
    beat_ready_i = 1'b0;
    rst_i = 1'b1;
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    @(negedge clk);
    check("midrst_beat_valid", 32'(beat_valid_o), 32'd0);
    check("midrst_slave_ready", 32'(slave_ready_o), 32'd1);
    check("midrst_sb_empty", 32'(sb.size()), 32'd0);
    @(posedge clk);
    #1;
    beat_ready_i = 1'b1;
    push_exp(32'h500, 3'd2, 4'd5, 1'b0, 1'b1);
    send_ar(32'h500, 8'd0, 3'd2, 2'b01, 4'd5, 1'b0);
    wait_drain("after_rst");
    repeat (3) @(posedge clk);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
